// File: rtl/axis_ann_pkg.sv
// Shared types and helpers for the vector stream transmitter.
// relu_clamp is only referenced when AXIS_TX_RELU_EN is defined.
package axis_ann_pkg;

  typedef enum logic {IDLE, SEND} tx_state_t;

  // Widest element relu_clamp accepts; callers sign-extend into it and truncate back.
  localparam int unsigned CLAMP_MAX_W = 64;

  function automatic logic [CLAMP_MAX_W-1:0] relu_clamp(input logic [CLAMP_MAX_W-1:0] x);
    return x[CLAMP_MAX_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/vec_shadow_buf.sv
// N x WIDTH shadow register bank with a common capture enable.
// With AXIS_TX_RELU_EN defined, negative elements are clamped to zero on capture.
module vec_shadow_buf
  import axis_ann_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [N*WIDTH-1:0] vec_in,
  output logic [N*WIDTH-1:0] data
);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_elem
      logic [WIDTH-1:0] elem_in;
      logic [WIDTH-1:0] elem_cap;
      logic [WIDTH-1:0] elem_reg;

      assign elem_in = vec_in[gi*WIDTH +: WIDTH];

`ifdef AXIS_TX_RELU_EN
      assign elem_cap = WIDTH'(relu_clamp(CLAMP_MAX_W'(signed'(elem_in))));
`else
      assign elem_cap = elem_in;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          elem_reg <= '0;
        else if (load)
          elem_reg <= elem_cap;
      end

      assign data[gi*WIDTH +: WIDTH] = elem_reg;
    end
  endgenerate

endmodule

// File: rtl/axis_vec_tx.sv
// Parallel-to-stream transmitter: captures N signed words on load and emits them as AXI4-Stream.
// Optional capture-time ReLU clamp via AXIS_TX_RELU_EN (see vec_shadow_buf).
module axis_vec_tx
  import axis_ann_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clr,
  input  logic [N*WIDTH-1:0] vec_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  tx_state_t          state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [IDX_W-1:0]   idx_next;
  logic               tvalid_reg;
  logic               tlast_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               capture;
  logic [N*WIDTH-1:0] buf_data;

  // busy is only ever low in IDLE, so this also drops loads during the final handshake.
  assign capture  = load && !clr && (state_reg == IDLE);
  assign idx_next = idx_reg + 1'b1;

  vec_shadow_buf #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .load   (capture),
    .vec_in (vec_in),
    .data   (buf_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else if (clr) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load) begin
            state_reg  <= SEND;
            idx_reg    <= '0;
            tvalid_reg <= 1'b1;
            tlast_reg  <= (LAST_IDX == '0);
            busy_reg   <= 1'b1;
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            if (idx_reg == LAST_IDX) begin
              state_reg  <= IDLE;
              idx_reg    <= '0;
              tvalid_reg <= 1'b0;
              tlast_reg  <= 1'b0;
              busy_reg   <= 1'b0;
              done_reg   <= 1'b1;
            end else begin
              idx_reg   <= idx_next;
              tlast_reg <= (idx_next == LAST_IDX);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Data mux reads only registered state, so tready never reaches an output combinationally.
  assign m_axis_tdata  = tvalid_reg ? buf_data[idx_reg*WIDTH +: WIDTH] : '0;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_axis_vec_tx.sv
// Directed bench for axis_vec_tx: N=4 instance for streaming/backpressure/clr/reset, N=1 for the single-beat case.
// Expected data follows the AXIS_TX_RELU_EN setting of the build.
module tb_axis_vec_tx;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic         tready = 1'b0;
  logic [4*W-1:0] vec = '0;
  logic         busy, done, tvalid, tlast;
  logic [W-1:0] tdata;

  logic         load1 = 1'b0;
  logic         tready1 = 1'b0;
  logic [W-1:0] vec1 = '0;
  logic         busy1, done1, tvalid1, tlast1;
  logic [W-1:0] tdata1;

  int n_checks = 0;
  int n_errors = 0;

  axis_vec_tx #(.WIDTH(W), .N(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .clr           (clr),
    .vec_in        (vec),
    .busy          (busy),
    .done          (done),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast)
  );

  axis_vec_tx #(.WIDTH(W), .N(1)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .load          (load1),
    .clr           (clr),
    .vec_in        (vec1),
    .busy          (busy1),
    .done          (done1),
    .m_axis_tdata  (tdata1),
    .m_axis_tvalid (tvalid1),
    .m_axis_tready (tready1),
    .m_axis_tlast  (tlast1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ex(input logic signed [W-1:0] x);
`ifdef AXIS_TX_RELU_EN
    return (x < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [4*W-1:0] pack4(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                           input logic signed [W-1:0] c, input logic signed [W-1:0] d);
    return {d, c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic signed [W-1:0] x, input logic last);
    check({tag, ".tvalid"}, 32'(tvalid), 32'd1);
    check({tag, ".tdata"}, 32'(tdata), 32'(ex(x)));
    check({tag, ".tlast"}, 32'(tlast), 32'(last));
    $display("beat %s: tdata=%0d tlast=%0b tready=%0b", tag, $signed(tdata), tlast, tready);
  endtask

  task automatic end_of_vec(input string tag);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".tvalid"}, 32'(tvalid), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst.tvalid", 32'(tvalid), 32'd0);
    check("rst.busy",   32'(busy),   32'd0);
    check("rst.done",   32'(done),   32'd0);
    check("rst.tlast",  32'(tlast),  32'd0);
    check("rst.tdata",  32'(tdata),  32'd0);
    check("rst.tvalid1", 32'(tvalid1), 32'd0);

    // 1: straight stream
    vec = pack4(-3, 7, 0, 32767); load = 1'b1; tready = 1'b1;
    tick(); load = 1'b0;
    beat("t1.b0", -3, 1'b0); check("t1.busy", 32'(busy), 32'd1); tick();
    beat("t1.b1", 7, 1'b0); tick();
    beat("t1.b2", 0, 1'b0); tick();
    beat("t1.b3", 32767, 1'b1); tick();
    end_of_vec("t1");
    tick();
    check("t1.done_pulse", 32'(done), 32'd0);

    // 2: backpressure at idx 1
    load = 1'b1;
    tick(); load = 1'b0;
    beat("t2.b0", -3, 1'b0); tick();
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat("t2.hold", 7, 1'b0); tick();
    end
    tready = 1'b1;
    beat("t2.b1", 7, 1'b0); tick();
    beat("t2.b2", 0, 1'b0); tick();
    beat("t2.b3", 32767, 1'b1); tick();
    end_of_vec("t2");
    tick();

    // 3: clr at idx 2, then a fresh vector
    load = 1'b1;
    tick(); load = 1'b0;
    beat("t3.b0", -3, 1'b0); tick();
    beat("t3.b1", 7, 1'b0); tick();
    beat("t3.b2", 0, 1'b0); clr = 1'b1;
    tick(); clr = 1'b0;
    check("t3.clr_tvalid", 32'(tvalid), 32'd0);
    check("t3.clr_busy",   32'(busy),   32'd0);
    check("t3.clr_done",   32'(done),   32'd0);
    tick();
    check("t3.clr_done2",  32'(done),   32'd0);
    vec = pack4(1, 2, 3, 4); load = 1'b1;
    tick(); load = 1'b0;
    beat("t3.n0", 1, 1'b0); tick();
    beat("t3.n1", 2, 1'b0); tick();
    beat("t3.n2", 3, 1'b0); tick();
    beat("t3.n3", 4, 1'b1); tick();
    end_of_vec("t3");
    tick();

    // 4: loads while busy are ignored; load in the done cycle starts a new vector
    vec = pack4(-3, 7, 0, 32767); load = 1'b1;
    tick(); load = 1'b0;
    beat("t4.b0", -3, 1'b0);
    vec = pack4(100, 200, 300, 400); load = 1'b1;
    tick(); load = 1'b0;
    beat("t4.b1", 7, 1'b0); tick();
    beat("t4.b2", 0, 1'b0); tick();
    beat("t4.b3", 32767, 1'b1); load = 1'b1;
    tick(); load = 1'b0;
    end_of_vec("t4");
    vec = pack4(11, -22, 33, -44); load = 1'b1;
    tick(); load = 1'b0;
    beat("t4.n0", 11, 1'b0); tick();
    beat("t4.n1", -22, 1'b0); tick();
    beat("t4.n2", 33, 1'b0); tick();
    beat("t4.n3", -44, 1'b1); tick();
    end_of_vec("t4n");
    tick();

    // 5: asynchronous reset mid-SEND, then the clamp vector
    vec = pack4(-3, 7, 0, 32767); load = 1'b1;
    tick(); load = 1'b0;
    beat("t5.b0", -3, 1'b0); tick();
    beat("t5.b1", 7, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("t5.rst_tvalid", 32'(tvalid), 32'd0);
    check("t5.rst_busy",   32'(busy),   32'd0);
    check("t5.rst_tlast",  32'(tlast),  32'd0);
    check("t5.rst_tdata",  32'(tdata),  32'd0);
    rst = 1'b0;
    tick();
    check("t5.post_tvalid", 32'(tvalid), 32'd0);
    vec = pack4(-5, 9, -1, 4); load = 1'b1;
    tick(); load = 1'b0;
    beat("t5.r0", -5, 1'b0); tick();
    beat("t5.r1", 9, 1'b0); tick();
    beat("t5.r2", -1, 1'b0); tick();
    beat("t5.r3", 4, 1'b1); tick();
    end_of_vec("t5");

    // 6: single-element vector
    vec1 = 16'hFFFF; load1 = 1'b1; tready1 = 1'b1;
    tick(); load1 = 1'b0;
    check("t6.tvalid", 32'(tvalid1), 32'd1);
    check("t6.tdata",  32'(tdata1),  32'(ex(-1)));
    check("t6.tlast",  32'(tlast1),  32'd1);
    check("t6.busy",   32'(busy1),   32'd1);
    $display("beat t6: tdata=%0d tlast=%0b", $signed(tdata1), tlast1);
    tick();
    check("t6.done",   32'(done1),   32'd1);
    check("t6.tvalid_end", 32'(tvalid1), 32'd0);
    tick();
    check("t6.done_pulse", 32'(done1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
